// File: rtl/amo_unit.sv
// amo_unit: multi-cycle sequencer for RV32A atomics (LR.W, SC.W, AMO*.W).
// Performs the read-modify-write on data memory, retires the old value or the
// SC status to the register file, and owns the single LR/SC reservation.
//
// Memory handshake: mem_req acts as "valid" and mem_ready as "ready". A
// transfer completes on a rising edge where both are high. While mem_req is
// high and mem_ready is low, mem_we/mem_addr/mem_wdata stay constant. For a
// read, mem_rdata is sampled on the completing edge. mem_ready is ignored
// whenever mem_req is low.
module amo_unit #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [4:0]        funct5,
  input  logic [4:0]        rd,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              reg_write,
  output logic [4:0]        write_reg,
  output logic [XLEN-1:0]   write_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_WB} state_t;

  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  function automatic logic is_legal(input logic [4:0] f);
    case (f)
      F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR,
      F_MIN, F_MAX, F_MINU, F_MAXU: is_legal = 1'b1;
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  // New memory value for an AMO; ties in min/max keep the old value.
  function automatic logic [XLEN-1:0] amo_calc(input logic [4:0] f,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] op);
    case (f)
      F_ADD:   amo_calc = old + op;
      F_XOR:   amo_calc = old ^ op;
      F_AND:   amo_calc = old & op;
      F_OR:    amo_calc = old | op;
      F_MIN:   amo_calc = ($signed(op) < $signed(old)) ? op : old;
      F_MAX:   amo_calc = ($signed(op) > $signed(old)) ? op : old;
      F_MINU:  amo_calc = (op < old) ? op : old;
      F_MAXU:  amo_calc = (op > old) ? op : old;
      default: amo_calc = op;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [4:0]        funct_q, funct_d;
  logic [4:0]        rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              status_q, status_d;
  logic              resv_valid_q, resv_valid_d;
  logic [ADDR_W-1:0] resv_addr_q, resv_addr_d;

  // State and operand registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      funct_q      <= '0;
      rd_q         <= '0;
      addr_q       <= '0;
      rs2_q        <= '0;
      old_q        <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      status_q     <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      funct_q      <= funct_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      rs2_q        <= rs2_d;
      old_q        <= old_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      status_q     <= status_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  // Next-state logic: launch, memory sequencing and reservation tracking.
  always_comb begin
    state_d      = state_q;
    funct_d      = funct_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    rs2_d        = rs2_q;
    old_d        = old_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    status_d     = status_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          funct_d  = funct5;
          rd_d     = rd;
          addr_d   = rs1_data[ADDR_W-1:0];
          rs2_d    = rs2_data;
          old_d    = '0;
          err_d    = 1'b0;
          status_d = 1'b0;
          // Any SC consumes the reservation, whatever its outcome.
          if (funct5 == F_SC) resv_valid_d = 1'b0;
          if (rs1_data[1:0] != 2'b00 || !is_legal(funct5)) begin
            err_d   = 1'b1;
            state_d = S_WB;
          end else if (funct5 != F_SC) begin
            state_d = S_READ;
          end else if (resv_valid_q && resv_addr_q == rs1_data[ADDR_W-1:0]) begin
            wdata_d = rs2_data;
            state_d = S_WRITE;
          end else begin
            status_d = 1'b1;
            state_d  = S_WB;
          end
        end
      end
      S_READ: begin
        if (mem_ready) begin
          old_d = mem_rdata;
          if (funct_q == F_LR) begin
            resv_valid_d = 1'b1;
            resv_addr_d  = addr_q;
            state_d      = S_WB;
          end else begin
            wdata_d = amo_calc(funct_q, mem_rdata, rs2_q);
            // A store to the reserved word breaks the reservation.
            if (resv_addr_q == addr_q) resv_valid_d = 1'b0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (mem_ready) state_d = S_WB;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_WB);
    error      = (state_q == S_WB) && err_q;
    mem_req    = (state_q == S_READ) || (state_q == S_WRITE);
    mem_we     = (state_q == S_WRITE);
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    reg_write  = (state_q == S_WB) && (rd_q != 5'd0) && !err_q;
    write_reg  = '0;
    write_data = '0;
    if (state_q == S_WB) begin
      write_reg  = rd_q;
      write_data = (funct_q == F_SC) ? {{(XLEN-1){1'b0}}, status_q} : old_q;
    end
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit with a behavioural data memory that can
// insert wait cycles before each mem_ready.
module tb_amo_unit;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [4:0]        funct5;
  logic [4:0]        rd;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              busy;
  logic              done;
  logic              error;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;
  logic              reg_write;
  logic [4:0]        write_reg;
  logic [XLEN-1:0]   write_data;
  logic [1:0]        dbg_state;

  int checks = 0;
  int fails  = 0;
  int wait_cycles = 0;
  int wait_cnt = 0;
  int req_cnt = 0;
  int wr_cnt = 0;
  logic [XLEN-1:0] mem [logic [ADDR_W-1:0]];

  amo_unit #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct5(funct5), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .busy(busy), .done(done),
    .error(error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory responder: raises mem_ready after wait_cycles stalled cycles.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (mem_req === 1'b1) begin
      if (wait_cnt >= wait_cycles) begin
        mem_ready = 1'b1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Memory write port and request bookkeeping.
  always @(posedge clk) begin
    if (mem_req === 1'b1) req_cnt++;
    if (mem_req === 1'b1 && mem_ready === 1'b1 && mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt++;
    end
  end

  // Issue one operation and return the write-back seen in the done cycle.
  task automatic do_op(input logic [4:0] f, input logic [4:0] r,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       output int lat, output logic rw, output logic [4:0] wr,
                       output logic [XLEN-1:0] wd, output logic er);
    @(negedge clk);
    start = 1'b1; funct5 = f; rd = r; rs1_data = a; rs2_data = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++; fails++;
      $display("FAIL op_timeout: funct5=%b addr=%h no done after %0d cycles", f, a, lat);
    end
    rw = reg_write; wr = write_reg; wd = write_data; er = error;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    start = 1'b0; funct5 = '0; rd = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, error, mem_req, mem_we, reg_write} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 000000",
                        {busy, done, error, mem_req, mem_we, reg_write});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || write_data !== '0 || write_reg !== '0) begin
      fails++; $display("FAIL reset_data: addr=%h wdata=%h wd=%h wr=%0d required all 0",
                        mem_addr, mem_wdata, write_data, write_reg);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      fails++; $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
  endtask

  task automatic test_amoadd();
    int lat; logic rw; logic [4:0] wr; logic [XLEN-1:0] wd; logic er;
    mem[32'h100] = 32'd5;
    do_op(F_ADD, 5'd7, 32'h100, 32'd3, lat, rw, wr, wd, er);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL add_latency: got %0d required 3", lat); end
    checks++;
    if ({rw, wr, er} !== {1'b1, 5'd7, 1'b0}) begin
      fails++; $display("FAIL add_wb_ctrl: rw=%b wr=%0d er=%b required 1 7 0", rw, wr, er);
    end
    checks++;
    if (wd !== 32'd5) begin fails++; $display("FAIL add_wb_data: got %h required 5", wd); end
    checks++;
    if (mem[32'h100] !== 32'd8) begin
      fails++; $display("FAIL add_mem: got %h required 8", mem[32'h100]);
    end
  endtask

  typedef struct {
    logic [4:0]      f;
    logic [XLEN-1:0] old;
    logic [XLEN-1:0] op;
    logic [XLEN-1:0] exp;
  } vec_t;

  task automatic test_alu_ops();
    vec_t v[10];
    int lat; logic rw; logic [4:0] wr; logic [XLEN-1:0] wd; logic er;
    v[0] = '{F_MIN,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    v[1] = '{F_MINU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    v[2] = '{F_MAX,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    v[3] = '{F_MAXU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    v[4] = '{F_SWAP, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0FF0_0F0F};
    v[5] = '{F_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0};
    v[6] = '{F_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
    v[7] = '{F_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF};
    v[8] = '{F_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    v[9] = '{F_MIN,  32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    for (int i = 0; i < 10; i++) begin
      mem[32'h400] = v[i].old;
      do_op(v[i].f, 5'd3, 32'h400, v[i].op, lat, rw, wr, wd, er);
      checks++;
      if (mem[32'h400] !== v[i].exp) begin
        fails++; $display("FAIL alu_mem[%0d]: funct5=%b got %h required %h",
                          i, v[i].f, mem[32'h400], v[i].exp);
      end
      checks++;
      if (wd !== v[i].old || rw !== 1'b1) begin
        fails++; $display("FAIL alu_wb[%0d]: got rw=%b wd=%h required 1 %h",
                          i, rw, wd, v[i].old);
      end
    end
  endtask

  task automatic test_lr_sc();
    int lat; logic rw; logic [4:0] wr; logic [XLEN-1:0] wd; logic er;
    int reqs;
    mem[32'h200] = 32'h55;
    do_op(F_LR, 5'd5, 32'h200, 32'h0, lat, rw, wr, wd, er);
    checks++;
    if (lat !== 2 || wd !== 32'h55 || wr !== 5'd5) begin
      fails++; $display("FAIL lr: lat=%0d wd=%h wr=%0d required 2 55 5", lat, wd, wr);
    end
    do_op(F_SC, 5'd6, 32'h200, 32'hAB, lat, rw, wr, wd, er);
    checks++;
    if (lat !== 2 || wd !== 32'd0 || rw !== 1'b1) begin
      fails++; $display("FAIL sc_ok: lat=%0d wd=%h rw=%b required 2 0 1", lat, wd, rw);
    end
    checks++;
    if (mem[32'h200] !== 32'hAB) begin
      fails++; $display("FAIL sc_ok_mem: got %h required ab", mem[32'h200]);
    end
    reqs = req_cnt;
    do_op(F_SC, 5'd6, 32'h200, 32'hCD, lat, rw, wr, wd, er);
    checks++;
    if (lat !== 1 || wd !== 32'd1 || req_cnt !== reqs) begin
      fails++; $display("FAIL sc_again: lat=%0d wd=%h reqs=%0d required 1 1 0",
                        lat, wd, req_cnt - reqs);
    end
  endtask

  task automatic test_resv_break();
    int lat; logic rw; logic [4:0] wr; logic [XLEN-1:0] wd; logic er;
    int wrs;
    do_op(F_LR, 5'd5, 32'h200, 32'h0, lat, rw, wr, wd, er);
    do_op(F_SWAP, 5'd8, 32'h200, 32'h11, lat, rw, wr, wd, er);
    checks++;
    if (wd !== 32'hAB) begin fails++; $display("FAIL swap_wb: got %h required ab", wd); end
    wrs = wr_cnt;
    do_op(F_SC, 5'd9, 32'h200, 32'h22, lat, rw, wr, wd, er);
    checks++;
    if (wd !== 32'd1 || wr_cnt !== wrs || mem[32'h200] !== 32'h11) begin
      fails++; $display("FAIL sc_after_swap: wd=%h writes=%0d mem=%h required 1 0 11",
                        wd, wr_cnt - wrs, mem[32'h200]);
    end
    do_op(F_LR, 5'd5, 32'h200, 32'h0, lat, rw, wr, wd, er);
    do_op(F_SC, 5'd9, 32'h204, 32'h33, lat, rw, wr, wd, er);
    checks++;
    if (wd !== 32'd1 || lat !== 1) begin
      fails++; $display("FAIL sc_other_addr: wd=%h lat=%0d required 1 1", wd, lat);
    end
    do_op(F_SC, 5'd9, 32'h200, 32'h44, lat, rw, wr, wd, er);
    checks++;
    if (wd !== 32'd1 || mem[32'h200] !== 32'h11) begin
      fails++; $display("FAIL sc_consumed: wd=%h mem=%h required 1 11", wd, mem[32'h200]);
    end
  endtask

  task automatic test_error_rd0();
    int lat; logic rw; logic [4:0] wr; logic [XLEN-1:0] wd; logic er;
    int reqs;
    reqs = req_cnt;
    do_op(F_OR, 5'd4, 32'h102, 32'hFF, lat, rw, wr, wd, er);
    checks++;
    if (lat !== 1 || er !== 1'b1 || rw !== 1'b0 || req_cnt !== reqs) begin
      fails++; $display("FAIL misaligned: lat=%0d er=%b rw=%b reqs=%0d required 1 1 0 0",
                        lat, er, rw, req_cnt - reqs);
    end
    do_op(5'b11111, 5'd4, 32'h100, 32'h1, lat, rw, wr, wd, er);
    checks++;
    if (lat !== 1 || er !== 1'b1 || rw !== 1'b0 || req_cnt !== reqs) begin
      fails++; $display("FAIL illegal_op: lat=%0d er=%b rw=%b reqs=%0d required 1 1 0 0",
                        lat, er, rw, req_cnt - reqs);
    end
    do_op(F_ADD, 5'd0, 32'h100, 32'h1, lat, rw, wr, wd, er);
    checks++;
    if (rw !== 1'b0 || er !== 1'b0 || mem[32'h100] !== 32'd9) begin
      fails++; $display("FAIL rd0: rw=%b er=%b mem=%h required 0 0 9", rw, er, mem[32'h100]);
    end
  endtask

  task automatic test_stall_reset();
    int lat; logic rw; logic [4:0] wr; logic [XLEN-1:0] wd; logic er;
    int wrs; int guard;
    logic [XLEN-1:0] a0, d0;
    mem[32'h600] = 32'h66;
    do_op(F_LR, 5'd5, 32'h600, 32'h0, lat, rw, wr, wd, er);
    mem[32'h500] = 32'd10;
    wait_cycles = 4;
    wrs = wr_cnt;
    @(negedge clk);
    start = 1'b1; funct5 = F_ADD; rd = 5'd2; rs1_data = 32'h500; rs2_data = 32'd1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (mem_we !== 1'b1 && guard < 30) begin @(negedge clk); guard++; end
    checks++;
    if (mem_we !== 1'b1 || mem_req !== 1'b1 || mem_wdata !== 32'd11) begin
      fails++; $display("FAIL stall_enter_write: we=%b req=%b wdata=%h required 1 1 b",
                        mem_we, mem_req, mem_wdata);
    end
    a0 = mem_addr; d0 = mem_wdata;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; funct5 = F_SWAP; rd = 5'd9; rs1_data = 32'h700; rs2_data = 32'hDEAD;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a0 || mem_wdata !== d0 ||
          busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL stall_stable[%0d]: req=%b we=%b addr=%h wdata=%h busy=%b done=%b",
                          i, mem_req, mem_we, mem_addr, mem_wdata, busy, done);
      end
    end
    start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || reg_write !== 1'b0) begin
      fails++; $display("FAIL async_reset: req=%b busy=%b rw=%b required 0 0 0",
                        mem_req, busy, reg_write);
    end
    wait_cycles = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (wr_cnt !== wrs || mem[32'h500] !== 32'd10) begin
      fails++; $display("FAIL reset_no_write: writes=%0d mem=%h required 0 a",
                        wr_cnt - wrs, mem[32'h500]);
    end
    do_op(F_SC, 5'd9, 32'h600, 32'h77, lat, rw, wr, wd, er);
    checks++;
    if (wd !== 32'd1 || mem[32'h600] !== 32'h66) begin
      fails++; $display("FAIL reset_resv: sc wd=%h mem=%h required 1 66", wd, mem[32'h600]);
    end
  endtask

  initial begin
    test_reset();
    test_amoadd();
    test_alu_ops();
    test_lr_sc();
    test_resv_break();
    test_error_rd0();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
